// File: rtl/sprite_linebuf_seq_pkg.sv
// Shared definitions for the sprite line buffer.
//   TRANSP_CODE_DEF : default cleared/transparent pixel code
//   LINE_WIDTH      : visible pixels per scanline (one bank)
//   RAM_DEPTH       : total entries across both banks
//   rd_state_e      : display read/clear FSM states
//   is_transp()     : transparency predicate on a sprite pixel code
package sprite_linebuf_seq_pkg;

  localparam logic [7:0] TRANSP_CODE_DEF = 8'hFF;
  localparam int         LINE_WIDTH      = 256;
  localparam int         RAM_DEPTH       = 2 * LINE_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CLEAR = 2'd2
  } rd_state_e;

  // Codes with bits [2:1] both set carry no visible colour.
  function automatic logic is_transp(input logic [7:0] code);
    return (code[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/sprite_linebuf_seq_dpram.sv
// Two-bank line storage, 512x8, two ports sharing one array.
//   clk     : clock
//   a_we    : port A write enable (sprite writes, reset sweep)
//   a_addr  : port A address, MSB = bank
//   a_wdata : port A write data
//   b_we    : port B write enable (display clear)
//   b_addr  : port B address, MSB = bank
//   b_wdata : port B write data
//   b_rdata : port B registered read data (1 clk latency, read-before-write)
module linebuf_dpram_512x8
  import sprite_linebuf_seq_pkg::*;
(
  input  logic       clk,
  input  logic       a_we,
  input  logic [8:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       b_we,
  input  logic [8:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic [7:0] b_rdata
);

  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] b_rdata_q;

  // Port A and port B normally target opposite banks; if they ever collide
  // both write the cleared code, so ordering is immaterial.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_q[a_addr] <= a_wdata;
    end
    if (b_we) begin
      mem_q[b_addr] <= b_wdata;
    end
    b_rdata_q <= mem_q[b_addr];
  end

  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sprite_linebuf_seq.sv
// Double-buffered sprite line buffer. One bank collects sprite pixels for the
// next scanline while the other is read out pixel by pixel and cleared behind
// the read so it is transparent when it becomes the write bank again.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, starts a full clear sweep
//   pix_ce     : pixel clock enable, starts one fetch
//   line_start : one-clk scanline start, swaps banks
//   hblank     : high outside visible pixels
//   bank_in    : colour bank for the next line, sampled at line_start
//   wr_valid   : sprite pixel write request
//   wr_ready   : write accepted when wr_valid & wr_ready
//   wr_x       : write column
//   wr_code    : sprite pixel code
//   SLD        : pixel code of the displayed line
//   SLBD7      : colour bank of the displayed line
//   H1_SD30_r  : output strobe, low for 1 clk when SLD updates
module sprite_linebuf_seq
  import sprite_linebuf_seq_pkg::*;
#(
  parameter logic [7:0] TRANSP_CODE = TRANSP_CODE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       line_start,
  input  logic       hblank,
  input  logic       bank_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [7:0] wr_code,
  output logic [7:0] SLD,
  output logic       SLBD7,
  output logic       H1_SD30_r
);

  rd_state_e  state_q, state_d;
  logic       disp_bank_q;
  logic [7:0] rd_x_q;
  logic       sweeping_q;
  logic [8:0] sweep_cnt_q;
  logic       ls_d1_q;
  logic [7:0] sld_q;
  logic       slbd7_q;
  logic       slbd7_next_q;
  logic       first_upd_q;
  logic       strobe_n_q;

  logic       wr_accept;
  logic       fetch_done;
  logic       a_we;
  logic [8:0] a_addr;
  logic [7:0] a_wdata;
  logic [8:0] b_addr;
  logic [7:0] b_rdata;

  // Read FSM: one fetch takes IDLE->READ->CLEAR->IDLE; line_start aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pix_ce && !hblank) state_d = ST_READ;
      ST_READ:  state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (line_start) begin
      state_d = ST_IDLE;
    end
  end

  // The CLEAR cycle both presents the fetched data and erases the entry;
  // an abort in that cycle drops both.
  assign fetch_done = (state_q == ST_CLEAR) && !line_start;

  // Writes are held off across the bank swap so none lands in the bank
  // that is about to be displayed.
  assign wr_ready  = !sweeping_q && !line_start && !ls_d1_q;
  assign wr_accept = wr_valid && wr_ready;

  assign a_we    = (sweeping_q && !reset) || (wr_accept && !is_transp(wr_code));
  assign a_addr  = sweeping_q ? sweep_cnt_q : {~disp_bank_q, wr_x};
  assign a_wdata = sweeping_q ? TRANSP_CODE : wr_code;

  assign b_addr  = {disp_bank_q, rd_x_q};

  linebuf_dpram_512x8 u_ram (
    .clk     (clk),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .b_we    (fetch_done),
    .b_addr  (b_addr),
    .b_wdata (TRANSP_CODE),
    .b_rdata (b_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      disp_bank_q  <= 1'b0;
      rd_x_q       <= 8'd0;
      sweeping_q   <= 1'b1;
      sweep_cnt_q  <= 9'd0;
      ls_d1_q      <= 1'b0;
      sld_q        <= TRANSP_CODE;
      slbd7_q      <= 1'b0;
      slbd7_next_q <= 1'b0;
      first_upd_q  <= 1'b0;
      strobe_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      ls_d1_q    <= line_start;
      strobe_n_q <= !fetch_done;

      if (sweeping_q) begin
        sweep_cnt_q <= sweep_cnt_q + 9'd1;
        if (sweep_cnt_q == 9'(RAM_DEPTH - 1)) begin
          sweeping_q <= 1'b0;
        end
      end

      if (line_start) begin
        disp_bank_q  <= ~disp_bank_q;
        rd_x_q       <= 8'd0;
        slbd7_next_q <= bank_in;
        first_upd_q  <= 1'b1;
      end else if (fetch_done) begin
        // Natural 8-bit wrap; the bank only changes on line_start.
        rd_x_q <= rd_x_q + 8'd1;
      end

      if (fetch_done) begin
        sld_q <= b_rdata;
        if (first_upd_q) begin
          slbd7_q     <= slbd7_next_q;
          first_upd_q <= 1'b0;
        end
      end
    end
  end

  assign SLD       = sld_q;
  assign SLBD7     = slbd7_q;
  assign H1_SD30_r = strobe_n_q || hblank;

endmodule

// File: tb/tb_sprite_linebuf_seq.sv
module tb_sprite_linebuf_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_ce = 1'b0;
  logic       line_start = 1'b0;
  logic       hblank = 1'b0;
  logic       bank_in = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = 8'd0;
  logic [7:0] wr_code = 8'd0;
  logic [7:0] SLD;
  logic       SLBD7;
  logic       H1_SD30_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_linebuf_seq dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .hblank     (hblank),
    .bank_in    (bank_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_code    (wr_code),
    .SLD        (SLD),
    .SLBD7      (SLBD7),
    .H1_SD30_r  (H1_SD30_r)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Holds the request until the handshake completes, bounded to 20 clk.
  task automatic do_write(input logic [7:0] x, input logic [7:0] code);
    bit done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_x     = x;
    wr_code  = code;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (wr_ready) done = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    $display("write x=%0d code=%02h accepted=%0d", x, code, done);
    check_eq("write_accept", 32'(done), 32'd1);
  endtask

  task automatic do_line(input logic bi);
    line_start = 1'b1;
    bank_in    = bi;
    tick();
    line_start = 1'b0;
    $display("line_start bank_in=%0d", bi);
  endtask

  // One pixel fetch: SLD sampled after the 2nd edge, strobe again 1 clk later.
  task automatic do_fetch(output logic [7:0] sld, output logic h_upd, output logic h_after);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    tick();
    tick();
    sld   = SLD;
    h_upd = H1_SD30_r;
    tick();
    h_after = H1_SD30_r;
    $display("fetch sld=%02h strobe=%0d then=%0d slbd7=%0d", sld, h_upd, h_after, SLBD7);
  endtask

  initial begin
    logic [7:0] s;
    logic       hu;
    logic       ha;
    int         bad;

    // Reset state
    repeat (3) tick();
    check_eq("rst_sld", 32'(SLD), 32'hFF);
    check_eq("rst_slbd7", 32'(SLBD7), 32'd0);
    check_eq("rst_strobe", 32'(H1_SD30_r), 32'd1);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;

    // Clear sweep: ready rises exactly 512 clk after reset release
    repeat (511) tick();
    check_eq("ready_at_511", 32'(wr_ready), 32'd0);
    tick();
    check_eq("ready_at_512", 32'(wr_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (dut.u_ram.mem_q[i] !== 8'hFF) bad++;
    end
    check_eq("sweep_all_ff", 32'(bad), 32'd0);

    // Opaque write into bank 1
    do_write(8'd10, 8'h21);

    // line_start with a write held: ready low 2 clk, then accepted into bank 0
    line_start = 1'b1;
    bank_in    = 1'b0;
    wr_valid   = 1'b1;
    wr_x       = 8'd5;
    wr_code    = 8'h30;
    #1 check_eq("ready_ls_cycle", 32'(wr_ready), 32'd0);
    tick();
    line_start = 1'b0;
    #1 check_eq("ready_ls_next", 32'(wr_ready), 32'd0);
    tick();
    #1 check_eq("ready_ls_after", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    $display("write x=5 code=30 held across line_start");

    // Display bank 1: x0..x9 cleared, x10 = 21
    for (int x = 0; x <= 10; x++) begin
      do_fetch(s, hu, ha);
      check_eq("d_strobe_low", 32'(hu), 32'd0);
      if (x < 10) check_eq("d_sld_ff", 32'(s), 32'hFF);
      else begin
        check_eq("d_sld_x10", 32'(s), 32'h21);
        check_eq("d_strobe_back", 32'(ha), 32'd1);
      end
    end

    // Transparent write to x5 leaves the 30 in place
    do_write(8'd5, 8'h07);
    do_line(1'b0);
    do_write(8'd11, 8'h52);
    for (int x = 0; x <= 5; x++) begin
      do_fetch(s, hu, ha);
    end
    check_eq("transp_keeps_30", 32'(s), 32'h30);

    // Bank 1 again: x10 was cleared by its previous display
    do_line(1'b0);
    for (int x = 0; x <= 10; x++) begin
      do_fetch(s, hu, ha);
    end
    check_eq("cleared_x10", 32'(s), 32'hFF);
    check_eq("slbd7_bank0", 32'(SLBD7), 32'd0);

    // Abort a fetch of x11 (=52) with line_start in READ, new bank_in=1
    do_write(8'd0, 8'h41);
    pix_ce = 1'b1;
    tick();
    pix_ce     = 1'b0;
    line_start = 1'b1;
    bank_in    = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check_eq("abort_sld_hold", 32'(SLD), 32'hFF);
    check_eq("abort_strobe", 32'(H1_SD30_r), 32'd1);
    check_eq("abort_slbd7_wait", 32'(SLBD7), 32'd0);
    tick();
    tick();
    check_eq("abort_sld_hold2", 32'(SLD), 32'hFF);
    $display("aborted fetch sld=%02h", SLD);

    // First fetch after abort reads x0 of the new bank
    do_fetch(s, hu, ha);
    check_eq("after_abort_x0", 32'(s), 32'h41);
    check_eq("slbd7_first_upd", 32'(SLBD7), 32'd1);

    // hblank rising during a fetch forces the strobe high
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    hblank = 1'b1;
    tick();
    tick();
    check_eq("hblank_strobe", 32'(H1_SD30_r), 32'd1);
    check_eq("hblank_sld_x1", 32'(SLD), 32'hFF);
    $display("hblank fetch sld=%02h strobe=%0d", SLD, H1_SD30_r);
    hblank = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
